// File: rtl/sequence_transmitter_if.sv
// Handshake and serial-output bundle for sequence_transmitter.
// The transmitter sits on the slave modport and the pattern source on the master modport.
interface sequence_transmitter_if #(
    parameter int WIDTH    = 4,
    parameter int REPEAT_W = 4
);
    logic [WIDTH-1:0]    data;
    logic [REPEAT_W-1:0] repeats;   // extra copies; copies sent = repeats + 1
    logic                start;
    logic                ready;
    logic                w;
    logic                valid;
    logic                done;

    modport master (
        output data, repeats, start,
        input  ready, w, valid, done
    );

    modport slave (
        input  data, repeats, start,
        output ready, w, valid, done
    );
endinterface

// File: rtl/sequence_transmitter.sv
// Serial pattern transmitter: shifts a captured WIDTH-bit word out MSB-first, repeats+1 times back-to-back.
// Define SEQUENCE_TX_PARITY_EN to append an even-parity bit after every copy.
module sequence_transmitter #(
    parameter int WIDTH    = 4,
    parameter int REPEAT_W = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    sequence_transmitter_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SEQUENCE_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t              state_reg, state_next;
    logic [WIDTH-1:0]    shift_reg, shift_next;
    logic [WIDTH-1:0]    hold_reg, hold_next;
    logic [CNT_W-1:0]    bit_reg, bit_next;
    logic [REPEAT_W-1:0] copy_reg, copy_next;
    logic                w_reg, w_next;
    logic                valid_reg, valid_next;
    logic                done_reg, done_next;
    logic                copy_end;

    // Outputs are computed one cycle ahead so w/valid/done leave straight from flops.
    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        hold_next  = hold_reg;
        bit_next   = bit_reg;
        copy_next  = copy_reg;
        w_next     = 1'b0;
        valid_next = 1'b0;
        done_next  = 1'b0;
        copy_end   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    hold_next  = bus.data;
                    shift_next = bus.data;
                    copy_next  = bus.repeats;
                    bit_next   = '0;
                    state_next = SHIFT;
                    w_next     = bus.data[WIDTH-1];
                    valid_next = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_reg != LAST_BIT) begin
                    shift_next = shift_reg << 1;
                    bit_next   = bit_reg + 1'b1;
                    w_next     = shift_reg[WIDTH-2];
                    valid_next = 1'b1;
                end else begin
`ifdef SEQUENCE_TX_PARITY_EN
                    state_next = PARITY;
                    w_next     = ^hold_reg;
                    valid_next = 1'b1;
`else
                    copy_end   = 1'b1;
`endif
                end
            end
`ifdef SEQUENCE_TX_PARITY_EN
            PARITY: copy_end = 1'b1;
`endif
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Counting down from repeats and stopping at zero yields repeats+1 copies without wrap.
        if (copy_end) begin
            if (copy_reg != '0) begin
                copy_next  = copy_reg - 1'b1;
                shift_next = hold_reg;
                bit_next   = '0;
                state_next = SHIFT;
                w_next     = hold_reg[WIDTH-1];
                valid_next = 1'b1;
            end else begin
                state_next = DONE;
                done_next  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            hold_reg  <= '0;
            bit_reg   <= '0;
            copy_reg  <= '0;
            w_reg     <= 1'b0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            hold_reg  <= hold_next;
            bit_reg   <= bit_next;
            copy_reg  <= copy_next;
            w_reg     <= w_next;
            valid_reg <= valid_next;
            done_reg  <= done_next;
        end
    end

    assign bus.ready = (state_reg == IDLE);
    assign bus.w     = w_reg;
    assign bus.valid = valid_reg;
    assign bus.done  = done_reg;
endmodule
